// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: instruction prefetcher and load/store path
// share one valid/ready memory port, one transaction at a time, with alternating
// grants under contention and a programmable response timeout.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   i_valid, i_addr           instruction request
//   i_ready, i_rdata, i_error instruction completion (one-cycle pulse)
//   d_valid, d_addr,
//   d_wdata, d_wstrb          data request (wstrb==0 is a load)
//   d_ready, d_rdata, d_error data completion (one-cycle pulse)
//   mem_valid, mem_instr,
//   mem_addr, mem_wdata,
//   mem_wstrb                 memory request
//   mem_ready, mem_rdata      memory completion
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CW      = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_error,

    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_error,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic          r_last_i,    w_last_i_nxt;   // 1: last grant went to instruction side
    logic [CW-1:0] r_cnt,       w_cnt_nxt;
    logic [31:0]   r_addr,      w_addr_nxt;
    logic [31:0]   r_wdata,     w_wdata_nxt;
    logic [3:0]    r_wstrb,     w_wstrb_nxt;
    logic          r_mem_valid, w_mem_valid_nxt;
    logic          r_mem_instr, w_mem_instr_nxt;
    logic          r_i_ready,   w_i_ready_nxt;
    logic [31:0]   r_i_rdata,   w_i_rdata_nxt;
    logic          r_i_error,   w_i_error_nxt;
    logic          r_d_ready,   w_d_ready_nxt;
    logic [31:0]   r_d_rdata,   w_d_rdata_nxt;
    logic          r_d_error,   w_d_error_nxt;

    logic w_grant_d;
    logic w_grant_i;
    logic w_timeout;

    // Data wins when alone, or on contention when instruction had the last grant.
    assign w_grant_d = d_valid & (~i_valid | r_last_i);
    assign w_grant_i = i_valid & ~w_grant_d;
    // mem_ready is checked before this, so it wins on the timeout edge.
    assign w_timeout = TO_EN && (r_cnt == TO_LAST);

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last_i    <= 1'b1;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_instr <= 1'b0;
            r_i_ready   <= 1'b0;
            r_i_rdata   <= '0;
            r_i_error   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_d_rdata   <= '0;
            r_d_error   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_i    <= w_last_i_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_instr <= w_mem_instr_nxt;
            r_i_ready   <= w_i_ready_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_i_error   <= w_i_error_nxt;
            r_d_ready   <= w_d_ready_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_d_error   <= w_d_error_nxt;
        end
    end

    // Next-state and next-output logic; completion outputs default to idle.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_i_nxt    = r_last_i;
        w_cnt_nxt       = r_cnt;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_instr_nxt = r_mem_instr;
        w_i_ready_nxt   = 1'b0;
        w_i_rdata_nxt   = '0;
        w_i_error_nxt   = 1'b0;
        w_d_ready_nxt   = 1'b0;
        w_d_rdata_nxt   = '0;
        w_d_error_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt     = BUSY_D;
                    w_last_i_nxt    = 1'b0;
                    w_cnt_nxt       = '0;
                    w_addr_nxt      = d_addr;
                    w_wdata_nxt     = d_wdata;
                    w_wstrb_nxt     = d_wstrb;
                    w_mem_valid_nxt = 1'b1;
                    w_mem_instr_nxt = 1'b0;
                end else if (w_grant_i) begin
                    w_state_nxt     = BUSY_I;
                    w_last_i_nxt    = 1'b1;
                    w_cnt_nxt       = '0;
                    w_addr_nxt      = i_addr;
                    w_wdata_nxt     = '0;
                    w_wstrb_nxt     = '0;
                    w_mem_valid_nxt = 1'b1;
                    w_mem_instr_nxt = 1'b1;
                end
            end

            BUSY_I: begin
                if (mem_ready) begin
                    w_state_nxt     = RESP;
                    w_mem_valid_nxt = 1'b0;
                    w_i_ready_nxt   = 1'b1;
                    w_i_rdata_nxt   = mem_rdata;
                end else if (w_timeout) begin
                    w_state_nxt     = RESP;
                    w_mem_valid_nxt = 1'b0;
                    w_i_ready_nxt   = 1'b1;
                    w_i_error_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            BUSY_D: begin
                if (mem_ready) begin
                    w_state_nxt     = RESP;
                    w_mem_valid_nxt = 1'b0;
                    w_d_ready_nxt   = 1'b1;
                    w_d_rdata_nxt   = mem_rdata;
                end else if (w_timeout) begin
                    w_state_nxt     = RESP;
                    w_mem_valid_nxt = 1'b0;
                    w_d_ready_nxt   = 1'b1;
                    w_d_error_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            // Requester still shows valid here, so no grant is taken.
            RESP: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign i_ready   = r_i_ready;
    assign i_rdata   = r_i_rdata;
    assign i_error   = r_i_error;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign d_error   = r_d_error;
    assign mem_valid = r_mem_valid;
    assign mem_instr = r_mem_instr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory requests and completions are
// queued by the stimulus and checked by independent monitors.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        i_error;
    logic        d_valid = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_error;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    mem_arbiter #(.TIMEOUT(4), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr),
        .i_ready(i_ready), .i_rdata(i_rdata), .i_error(i_error),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_error(d_error),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] XK = 32'h5A5A_0000;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic        is_i;
        logic [31:0] rdata;
        logic        err;
    } cmp_t;

    req_t q_req[$];
    cmp_t q_cmp[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Memory model: answers mem_lat cycles after the request appears; <0 never.
    int          mem_lat  = 0;
    int          mem_wait = 0;
    bit          use_xor  = 0;
    logic [31:0] mem_rsp  = '0;
    logic        model_ready = 1'b0;
    logic        pulse_ready = 1'b0;

    assign mem_ready = model_ready | pulse_ready;
    assign mem_rdata = use_xor ? (mem_addr ^ XK) : mem_rsp;

    always @(negedge clk) begin
        if (mem_valid && !rst) begin
            model_ready = (mem_lat >= 0) && (mem_wait == mem_lat);
            mem_wait++;
        end else begin
            model_ready = 1'b0;
            mem_wait    = 0;
        end
    end

    // Requesters: hold valid until the requested number of completions arrive.
    int i_left = 0;
    int d_left = 0;

    always @(negedge clk) begin
        if (i_ready && i_left > 0) begin
            i_left--;
            if (i_left == 0) i_valid = 1'b0;
        end
        if (d_ready && d_left > 0) begin
            d_left--;
            if (d_left == 0) d_valid = 1'b0;
        end
    end

    // Request monitor: each new mem_valid is checked against the next queued request;
    // also measures how long each request stays up.
    logic prev_mv = 1'b0;
    int   mv_run  = 0;
    int   exp_mv_len = -1;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_valid && !prev_mv) begin
                if (q_req.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_mem_req actual=%h required=none", mem_addr);
                end else begin
                    req_t r;
                    r = q_req.pop_front();
                    chk("mem_instr", 32'(mem_instr), 32'(r.instr));
                    chk("mem_addr",  mem_addr,  r.addr);
                    chk("mem_wdata", mem_wdata, r.wdata);
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(r.wstrb));
                end
            end
            if (mem_valid) begin
                mv_run++;
            end else if (mv_run > 0) begin
                if (exp_mv_len > 0) chk("mem_valid_len", 32'(mv_run), 32'(exp_mv_len));
                mv_run = 0;
            end
        end else begin
            mv_run = 0;
        end
        prev_mv = mem_valid;
    end

    // Completion monitor.
    logic prev_ir = 1'b0;
    logic prev_dr = 1'b0;

    always @(negedge clk) begin
        if (!rst && (i_ready || d_ready)) begin
            chk("one_ready", 32'(i_ready & d_ready), 32'd0);
            chk("ready_pulse", 32'((i_ready & prev_ir) | (d_ready & prev_dr)), 32'd0);
            chk("mv_low_in_resp", 32'(mem_valid), 32'd0);
            if (q_cmp.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ready actual=i%0b/d%0b required=none", i_ready, d_ready);
            end else begin
                cmp_t c;
                c = q_cmp.pop_front();
                chk("cmp_who",   32'(i_ready), 32'(c.is_i));
                chk("cmp_rdata", i_ready ? i_rdata : d_rdata, c.rdata);
                chk("cmp_error", 32'(i_ready ? i_error : d_error), 32'(c.err));
            end
        end
        prev_ir = i_ready;
        prev_dr = d_ready;
    end

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((q_cmp.size() != 0 || i_valid || d_valid) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d_pending required=0", name, q_cmp.size());
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q_req.delete();
        q_cmp.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_readies",   32'({i_ready, d_ready, i_error, d_error}), 32'd0);
        chk("rst_mem_addr",  mem_addr, 32'd0);
        chk("rst_rdata",     i_rdata | d_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch, memory answers one cycle after mem_valid
        mem_lat = 1; use_xor = 0; mem_rsp = 32'h0000_0013; exp_mv_len = 2;
        q_req.push_back('{1'b1, 32'h100, 32'h0, 4'h0});
        q_cmp.push_back('{1'b1, 32'h13, 1'b0});
        i_addr = 32'h100; i_left = 1; i_valid = 1'b1;
        wait_done("fetch", 50);

        // Data store, zero-wait
        @(negedge clk);
        mem_lat = 0; mem_rsp = 32'h1234_5678; exp_mv_len = 1;
        q_req.push_back('{1'b0, 32'h2000, 32'hDEAD_BEEF, 4'hF});
        q_cmp.push_back('{1'b0, 32'h1234_5678, 1'b0});
        d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; d_left = 1; d_valid = 1'b1;
        wait_done("store", 50);

        // Contention from reset: grants D, I, D, I
        @(negedge clk);
        rst = 1'b1;
        use_xor = 1; mem_lat = 0; exp_mv_len = 1;
        i_addr = 32'h300; d_addr = 32'h400; d_wdata = 32'h11; d_wstrb = 4'h3;
        i_left = 2; d_left = 2; i_valid = 1'b1; d_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q_req.push_back('{1'b0, 32'h400, 32'h11, 4'h3});
            q_req.push_back('{1'b1, 32'h300, 32'h0, 4'h0});
            q_cmp.push_back('{1'b0, 32'h400 ^ XK, 1'b0});
            q_cmp.push_back('{1'b1, 32'h300 ^ XK, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        wait_done("contend", 100);

        // Timeout: fetch never answered
        @(negedge clk);
        use_xor = 0; mem_lat = -1; mem_rsp = 32'hFFFF_FFFF; exp_mv_len = 4;
        q_req.push_back('{1'b1, 32'h500, 32'h0, 4'h0});
        q_cmp.push_back('{1'b1, 32'h0, 1'b1});
        i_addr = 32'h500; i_left = 1; i_valid = 1'b1;
        wait_done("timeout", 50);

        // Stray mem_ready while idle is ignored
        @(negedge clk);
        pulse_ready = 1'b1;
        @(negedge clk);
        pulse_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_ignore", 32'({i_ready, d_ready, mem_valid}), 32'd0);
        end

        // mem_ready on the timeout edge wins
        mem_lat = 3; mem_rsp = 32'hCAFE_0001; exp_mv_len = 4;
        q_req.push_back('{1'b1, 32'h540, 32'h0, 4'h0});
        q_cmp.push_back('{1'b1, 32'hCAFE_0001, 1'b0});
        i_addr = 32'h540; i_left = 1; i_valid = 1'b1;
        wait_done("to_edge", 50);

        // Asynchronous reset in BUSY_D
        @(negedge clk);
        mem_lat = -1; exp_mv_len = -1;
        q_req.push_back('{1'b0, 32'h700, 32'h0, 4'h0});
        d_addr = 32'h700; d_wdata = 32'h0; d_wstrb = 4'h0; d_left = 1; d_valid = 1'b1;
        begin
            int n = 0;
            while (!mem_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("busy_d_reached", 32'(mem_valid), 32'd1);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("async_rst_d_ready",   32'(d_ready), 32'd0);
        d_valid = 1'b0; d_left = 0;
        q_req.delete();
        q_cmp.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(mem_valid), 32'd0);

        // Fresh request after reset
        mem_lat = 0; mem_rsp = 32'h0000_0077; exp_mv_len = 1;
        q_req.push_back('{1'b1, 32'h600, 32'h0, 4'h0});
        q_cmp.push_back('{1'b1, 32'h77, 1'b0});
        i_addr = 32'h600; i_left = 1; i_valid = 1'b1;
        wait_done("post_rst", 50);

        chk("req_queue_drained", 32'(q_req.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single memory port between the instruction prefetcher (ireq) and the load/store path (dreq).
- Uses the team's valid/ready memory handshake: valid, instr, addr, wdata, wstrb in; ready, rdata back.
- Sequences one transaction at a time and alternates grants when both requesters contend.
- Converts a hung memory response into an error completion after a programmable timeout.

Parameters:
- TIMEOUT, 256: cycles of unanswered mem_valid before a transaction is force-completed with error. 0 disables the timeout.
- CW, 16: timeout counter width. Must satisfy 2**CW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- i_valid  in  1  instruction request; held stable until i_ready.
- i_addr  in  32  instruction address.
- i_ready  out  1  one-cycle completion pulse to the instruction requester.
- i_rdata  out  32  instruction read data; valid while i_ready=1.
- i_error  out  1  completion was a timeout; valid while i_ready=1.
- d_valid  in  1  data request; held stable until d_ready.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  byte strobes; 0 means load.
- d_ready  out  1  one-cycle completion pulse to the data requester.
- d_rdata  out  32  load data; valid while d_ready=1.
- d_error  out  1  completion was a timeout; valid while d_ready=1.
- mem_valid  out  1  memory request; held until mem_ready or timeout.
- mem_instr  out  1  1 = instruction fetch, 0 = data access.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte strobes.
- mem_ready  in  1  memory completion.
- mem_rdata  in  32  memory read data; valid with mem_ready.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; timeout counter 0.
  - last_grant = INSTR, so data wins the first contention.
  - Reset asserted mid-transaction aborts immediately: mem_valid drops asynchronously and no ready is issued. The memory side must tolerate a withdrawn request.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Neither valid: stay.
  - Exactly one valid: grant it.
  - Both valid: grant the requester that is not last_grant, then update last_grant.
  - Grant edge: capture addr/wdata/wstrb into holding registers (instruction grant captures wdata=0, wstrb=0) and enter BUSY_x.
  - From this same edge: mem_valid=1, mem_instr = (x==I), mem_* driven from the holding registers.
- BUSY_x:
  - mem_valid held at 1 with constant fields.
  - Counter increments on each cycle without mem_ready.
  - On the edge with mem_ready=1: mem_valid→0, x_rdata←mem_rdata, x_error←0, x_ready←1, go to RESP.
  - Otherwise, if TIMEOUT≠0 and counter == TIMEOUT-1: mem_valid→0, x_rdata←0, x_error←1, x_ready←1, go to RESP.
  - mem_ready takes precedence over timeout on the same edge.
- RESP (exactly one cycle):
  - x_ready=1 with rdata/error valid.
  - No grant is evaluated in this cycle, because the requester still shows valid.
  - Next edge: x_ready, x_rdata and x_error→0; go to IDLE; counter cleared.
- Latency:
  - Request seen at edge N → mem_valid from N+1.
  - mem_ready at edge M → x_ready high for the cycle after M.
  - Minimum round trip with zero-wait memory: 3 cycles request-to-ready; next grant is possible 1 cycle after RESP.
- Ignored inputs:
  - mem_ready while in IDLE or RESP.
  - Request fields that change while not granted.
  - A non-granted valid stays pending; it is not lost.
- Stores complete like loads; rdata carries whatever mem_rdata returned.
- Starvation bound: under continuous contention grants strictly alternate I, D, I, D.

Test Plan:
- Single fetch: i_valid, i_addr=0x100, memory returns 0x00000013 one cycle after mem_valid → mem_instr=1, mem_addr=0x100; i_ready one cycle with i_rdata=0x13, i_error=0; d_ready stays 0.
- Data store: d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF → mem_instr=0, mem_wstrb=0xF, mem_wdata=0xDEADBEEF; d_ready pulse after mem_ready; mem_valid low during RESP.
- Contention: both valid from reset and held, memory zero-wait → grant order D, I, D, I; no cycle with both readies high; each ready exactly one cycle.
- Timeout: TIMEOUT=4, memory never answers a fetch → mem_valid high exactly 4 cycles, then i_ready=1, i_error=1, i_rdata=0; a later mem_ready pulse in IDLE is ignored.
- Ready on the timeout edge: TIMEOUT=4, mem_ready on the 4th cycle → normal completion with i_error=0.
- Reset mid-op: assert rst while in BUSY_D, asynchronously between clock edges → mem_valid and d_ready 0 immediately; after release the arbiter is in IDLE and a fresh request completes normally.
